l2_cacheline_adaptor: RTL

Memory-side responder for the L2 cache controller's `read_from_mem` / `write_to_mem` / `resp_from_mem` interface. It accepts one 256-bit cacheline request at a time and carries it out as a 4-beat, 64-bit burst on the physical memory port. It then returns a single-cycle response upstream. It sits between the L2 datapath/control and main memory, and serves both line fills and eviction-write-buffer writebacks.

---
 rtl/l2_pkg.sv | 21 ++
 rtl/l2_cacheline_adaptor.sv | 109 ++++++++++
 2 files changed

// File: rtl/l2_pkg.sv
// Shared constants and types for the L2 memory-side path: line/beat widths,
// line offset and the cacheline adaptor state encoding.
package l2_pkg;

  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int ADDR_W  = 32;
  localparam int BEATS   = LINE_W / BURST_W;
  localparam int OFS     = $clog2(LINE_W / 8);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } adaptor_state_t;

  typedef logic [LINE_W-1:0]  line_t;
  typedef logic [BURST_W-1:0] beat_t;

endpackage

// File: rtl/l2_cacheline_adaptor.sv
// Turns one L2 cacheline read/write request into a 4-beat memory burst and
// returns a single-cycle completion pulse upstream.
module l2_cacheline_adaptor #(
  parameter int LINE_W  = l2_pkg::LINE_W,
  parameter int BURST_W = l2_pkg::BURST_W,
  parameter int ADDR_W  = l2_pkg::ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);
  import l2_pkg::*;

  localparam int N_BEATS  = LINE_W / BURST_W;
  localparam int ADDR_OFS = $clog2(LINE_W / 8);
  localparam int CNT_W    = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << ADDR_OFS) - ADDR_W'(1));

  adaptor_state_t     state;
  adaptor_state_t     state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [LINE_W-1:0]  wr_line;
  logic [LINE_W-1:0]  rd_line;
  logic [ADDR_W-1:0]  addr_q;
  logic               last_beat;

  assign last_beat = resp_i && (cnt == CNT_W'(N_BEATS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Write takes priority; a simultaneous read is still held by L2 and gets
  // picked up in the IDLE cycle after DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (write_i) begin
          state_nxt = WRITE;
        end else if (read_i) begin
          state_nxt = READ;
        end
      end
      READ:    if (last_beat) state_nxt = DONE;
      WRITE:   if (last_beat) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The line offset is stripped at latch time so the burst address is
  // line-aligned and stays constant for the whole burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      wr_line <= '0;
      rd_line <= '0;
      addr_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (write_i) begin
            wr_line <= line_i;
            addr_q  <= address_i & LINE_MASK;
          end else if (read_i) begin
            addr_q  <= address_i & LINE_MASK;
          end
        end
        READ: begin
          if (resp_i) begin
            rd_line[int'(cnt)*BURST_W +: BURST_W] <= burst_i;
            cnt <= cnt + CNT_W'(1);
          end
        end
        WRITE: begin
          if (resp_i) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign read_o    = (state == READ);
  assign write_o   = (state == WRITE);
  assign resp_o    = (state == DONE);
  assign line_o    = rd_line;
  assign address_o = addr_q;
  assign burst_o   = wr_line[int'(cnt)*BURST_W +: BURST_W];

endmodule
